// File: rtl/tt_stim_pkg.sv
// Shared types and constants for the tt_um_* stimulus sequencer.
// The LFSR constants are only used when TT_STIM_LFSR_EN is defined.
package tt_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int          MAX_CH    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/tt_stim_pattern.sv
// Per-epoch button pattern: walking one by default, 16-bit LFSR when TT_STIM_LFSR_EN is defined.
// init restarts the sequence at pattern(0); step advances to the next epoch's pattern.
module tt_stim_pattern
    import tt_stim_pkg::*;
#(
    parameter int CH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init,
    input  logic          step,
    output logic [CH-1:0] pattern
);

`ifdef TT_STIM_LFSR_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n || init)
            lfsr <= LFSR_SEED;
        else if (step)
            lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end

    assign pattern = lfsr[CH-1:0];
`else
    localparam int IW = (CH > 1) ? $clog2(CH) : 1;

    logic [IW-1:0] idx;

    always_ff @(posedge clk) begin
        if (!rst_n || init)
            idx <= '0;
        else if (step)
            idx <= (idx == IW'(CH-1)) ? '0 : idx + IW'(1);
    end

    assign pattern = CH'(1) << idx;
`endif

endmodule

// File: rtl/tt_stim_seq.sv
// Stimulus sequencer for tt_um_* designs: DUT reset, timed RUN with periodic button presses, DONE.
// Define TT_STIM_LFSR_EN to replace the walking-one press pattern with an LFSR pattern.
module tt_stim_seq
    import tt_stim_pkg::*;
#(
    parameter int CH           = 8,
    parameter int RST_CYCLES   = 3,
    parameter int RUN_CYCLES   = 1680000,
    parameter int PRESS_PERIOD = 420000,
    parameter int PRESS_LEN    = 1000,
    parameter int CNT_W        = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          dut_rst_n,
    output logic          ena,
    output logic [CH-1:0] ui_out,
    output logic          running,
    output logic          done,
    output logic          aborted,
    output logic [15:0]   epoch_cnt
);

    generate
        if (CH < 1 || CH > MAX_CH)
            $fatal(1, "tt_stim_seq: CH must be 1..%0d", MAX_CH);
        if (RST_CYCLES < 1)
            $fatal(1, "tt_stim_seq: RST_CYCLES must be >= 1");
        if (RUN_CYCLES < 1)
            $fatal(1, "tt_stim_seq: RUN_CYCLES must be >= 1");
        if (PRESS_PERIOD < 2)
            $fatal(1, "tt_stim_seq: PRESS_PERIOD must be >= 2");
        if (PRESS_LEN < 1 || PRESS_LEN >= PRESS_PERIOD)
            $fatal(1, "tt_stim_seq: PRESS_LEN must be 1..PRESS_PERIOD-1");
    endgenerate

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PRESS_PERIOD - 1);
    localparam logic [CNT_W-1:0] PH_STEP  = CNT_W'(PRESS_PERIOD - 2);
    localparam logic [CNT_W-1:0] PL_C     = CNT_W'(PRESS_LEN);

    state_t           state;
    logic [CNT_W-1:0] rst_cnt;
    logic [CNT_W-1:0] run_k;
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] phase_inc;
    logic [CH-1:0]    pattern;
    logic             pat_init;
    logic             pat_step;

    assign phase_inc = phase + CNT_W'(1);
    assign pat_init  = start && (state == ST_IDLE || state == ST_DONE);
    // Advance on entry to the epoch's last cycle: always outside the press window,
    // so the next epoch's pattern is already settled when ui_out registers it.
    assign pat_step  = (state == ST_RUN) && (phase == PH_STEP);

    tt_stim_pattern #(.CH(CH)) u_pat (
        .clk     (clk),
        .rst_n   (rst_n),
        .init    (pat_init),
        .step    (pat_step),
        .pattern (pattern)
    );

    // Outputs are registered for the cycle being entered, so they track state with no lag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rst_cnt   <= '0;
            run_k     <= '0;
            phase     <= '0;
            dut_rst_n <= 1'b0;
            ena       <= 1'b0;
            ui_out    <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            epoch_cnt <= '0;
        end else if (pat_init) begin
            state     <= ST_RESET;
            rst_cnt   <= '0;
            dut_rst_n <= 1'b0;
            ena       <= 1'b1;
            ui_out    <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            epoch_cnt <= '0;
        end else begin
            case (state)
                ST_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        state     <= ST_RUN;
                        run_k     <= '0;
                        phase     <= '0;
                        dut_rst_n <= 1'b1;
                        running   <= 1'b1;
                        ui_out    <= pattern;
                        epoch_cnt <= 16'd1;
                    end else begin
                        rst_cnt <= rst_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (abort || run_k == RUN_LAST) begin
                        state   <= ST_DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                        aborted <= abort;
                        ui_out  <= '0;
                    end else begin
                        run_k <= run_k + CNT_W'(1);
                        if (phase == PH_LAST) begin
                            phase  <= '0;
                            ui_out <= pattern;
                            if (epoch_cnt != 16'hFFFF)
                                epoch_cnt <= epoch_cnt + 16'd1;
                        end else begin
                            phase  <= phase_inc;
                            ui_out <= (phase_inc < PL_C) ? pattern : '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_stim_seq.sv
// Self-checking bench for tt_stim_seq with CH=4, RST=3, RUN=40, PERIOD=10, LEN=2.
// Expected outputs come from a cycle-index model of the sequencer's documented behaviour.
module tb_tt_stim_seq;

    localparam int CH   = 4;
    localparam int RSTC = 3;
    localparam int RUNC = 40;
    localparam int PER  = 10;
    localparam int PL   = 2;

    typedef logic [5+CH+16-1:0] obs_t;

    logic          clk = 1'b0;
    logic          rst_n, start, abort;
    logic          dut_rst_n, ena, running, done, aborted;
    logic [CH-1:0] ui_out;
    logic [15:0]   epoch_cnt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tt_stim_seq #(
        .CH(CH), .RST_CYCLES(RSTC), .RUN_CYCLES(RUNC),
        .PRESS_PERIOD(PER), .PRESS_LEN(PL), .CNT_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_rst_n(dut_rst_n), .ena(ena), .ui_out(ui_out), .running(running),
        .done(done), .aborted(aborted), .epoch_cnt(epoch_cnt)
    );

    function automatic logic [CH-1:0] ref_pat(input int e);
`ifdef TT_STIM_LFSR_EN
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < e; i++)
            s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        return s[CH-1:0];
`else
        return CH'(1 << (e % CH));
`endif
    endfunction

    function automatic logic [CH-1:0] ref_ui(input int k);
        return ((k % PER) < PL) ? ref_pat(k / PER) : '0;
    endfunction

    function automatic obs_t obs();
        return {dut_rst_n, ena, running, done, aborted, ui_out, epoch_cnt};
    endfunction

    function automatic obs_t mk(input logic r, input logic en, input logic rn, input logic dn,
                                input logic ab, input logic [CH-1:0] u, input int ep);
        return {r, en, rn, dn, ab, u, 16'(ep)};
    endfunction

    // One complete start->DONE pass; abort_k/rst_k/start_k < 0 disable that event.
    task automatic test_run_scenario(input string name, input int abort_k, input int rst_k,
                                     input int start_k);
        obs_t exp;
        int   last_k;
        logic ab;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < RSTC; c++) begin
            exp = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 0);
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL %s reset c=%0d: got %h want %h", name, c, obs(), exp);
            end
            @(negedge clk);
        end
        last_k = RUNC - 1;
        ab     = 1'b0;
        for (int k = 0; k < RUNC; k++) begin
            exp = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ref_ui(k), k / PER + 1);
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL %s run k=%0d: got %h want %h", name, k, obs(), exp);
            end
            start = (k == start_k);
            abort = (k == abort_k);
            if (k == rst_k) begin
                rst_n = 1'b0;
                start = 1'b1;
            end
            @(negedge clk);
            abort = 1'b0;
            if (k == rst_k) begin
                vectors++;
                if (obs() !== '0) begin
                    miscompares++;
                    $display("FAIL %s midrst k=%0d: got %h want 0", name, k, obs());
                end
                return;
            end
            start = 1'b0;
            if (k == abort_k) begin
                last_k = k;
                ab     = 1'b1;
                break;
            end
        end
        for (int h = 0; h < 2; h++) begin
            exp = mk(1'b1, 1'b1, 1'b0, 1'b1, ab, '0, last_k / PER + 1);
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL %s done h=%0d: got %h want %h", name, h, obs(), exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (obs() !== '0) begin
                miscompares++;
                $display("FAIL reset: got %h want 0", obs());
            end
        end
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (obs() !== '0) begin
                miscompares++;
                $display("FAIL idle_hold: got %h want 0", obs());
            end
        end
    endtask

    task automatic test_full_run();
        test_run_scenario("full_run", -1, -1, -1);
    endtask

    task automatic test_abort();
        test_run_scenario("abort15", 15, -1, -1);
        test_run_scenario("abort_last", RUNC - 1, -1, -1);
        test_run_scenario("abort_k0", 0, -1, -1);
        repeat (3) test_run_scenario("abort_rand", int'($urandom_range(0, RUNC - 1)), -1, -1);
    endtask

    task automatic test_mid_reset(input int k);
        test_run_scenario("mid_reset", -1, k, -1);
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (obs() !== '0) begin
                miscompares++;
                $display("FAIL mid_reset_hold: got %h want 0", obs());
            end
        end
        rst_n = 1'b1;
        test_run_scenario("after_reset", -1, -1, -1);
    endtask

    task automatic test_restart();
        test_run_scenario("start_in_run", -1, -1, int'($urandom_range(0, RUNC - 2)));
        test_run_scenario("restart", -1, -1, int'($urandom_range(0, RUNC - 2)));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        test_reset();
        test_full_run();
        test_abort();
        test_mid_reset(12);
        test_mid_reset(int'($urandom_range(0, RUNC - 1)));
        test_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
